// File: rtl/ucsbece154b_mem_burst_reader.sv
// Cache-line fill reader: fetches BLOCK_WORDS words critical-word-first from a
// combinational memory port and pushes them into a FIFO with SDRAM-like timing.
module ucsbece154b_mem_burst_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BLOCK_WORDS   = 4,
    parameter int FIRST_LATENCY = 10,
    parameter int NEXT_LATENCY  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  fifo_push_o,
    input  logic                  fifo_full_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int OFFW  = $clog2(BLOCK_WORDS);
    localparam int MAXFN = (FIRST_LATENCY > NEXT_LATENCY) ? FIRST_LATENCY : NEXT_LATENCY;
    localparam int MAXV  = (MAXFN > BLOCK_WORDS) ? MAXFN : BLOCK_WORDS;
    localparam int CNT_W = $clog2(MAXV + 1);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(FIRST_LATENCY - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((NEXT_LATENCY >= 2) ? NEXT_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [OFFW-1:0]  OFF_ONE    = OFFW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, PUSH, GAP} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:OFFW+2]   base_q, base_d;
    logic [OFFW-1:0]              offset_q, offset_d;
    logic [CNT_W-1:0]             beat_q, beat_d;
    logic [CNT_W-1:0]             wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]        last_addr_q;
    logic [ADDR_WIDTH-1:0]        cur_addr;
    logic                         unused_addr_bits;

    // Byte-lane bits never reach the memory port.
    assign unused_addr_bits = ^req_addr_i[1:0];

    assign cur_addr    = {base_q, offset_q, 2'b00};
    assign mem_addr_o  = (state_q == PUSH) ? cur_addr : last_addr_q;
    assign fifo_data_o = mem_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            offset_q    <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            last_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            if (state_q == PUSH) begin
                last_addr_q <= cur_addr;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        offset_d    = offset_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        req_ready_o = 1'b0;
        busy_o      = 1'b0;
        fifo_push_o = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    base_d   = req_addr_i[ADDR_WIDTH-1:OFFW+2];
                    offset_d = req_addr_i[OFFW+1:2];
                    beat_d   = '0;
                    wait_d   = FIRST_LOAD;
                    state_d  = (FIRST_LATENCY == 1) ? PUSH : WAIT;
                end
            end
            // Leaves on the count reaching 1 so the first push lands FIRST_LATENCY
            // cycles after the handshake.
            WAIT: begin
                busy_o = 1'b1;
                wait_d = wait_q - ONE;
                if (wait_q <= ONE) begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                busy_o = 1'b1;
                if (!fifo_full_i) begin
                    fifo_push_o = 1'b1;
                    offset_d    = offset_q + OFF_ONE;
                    beat_d      = beat_q + ONE;
                    if (beat_q == LAST_BEAT) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else if (NEXT_LATENCY != 1) begin
                        wait_d  = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                busy_o = 1'b1;
                wait_d = wait_q - ONE;
                if (wait_q == '0) begin
                    state_d = PUSH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
